// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU command issuer: opcode values, FSM encoding
// and the layout of a buffered command entry.
package alu_issue_pkg;

   localparam logic [3:0] SEQ   = 4'd0;
   localparam logic [3:0] XNOR  = 4'd1;
   localparam logic [3:0] NAND  = 4'd2;
   localparam logic [3:0] AND   = 4'd3;
   localparam logic [3:0] SLT   = 4'd4;
   localparam logic [3:0] PASSB = 4'd5;
   localparam logic [3:0] ADD   = 4'd6;
   localparam logic [3:0] MUL   = 4'd7;
   localparam logic [3:0] SLTU  = 4'd8;

   localparam int NUM_OPS_DEF = 9;

   localparam int OPC_W   = 4;
   localparam int SHAMT_W = 5;
   localparam int TAG_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_RESP  = 2'd2
   } issue_state_t;

   // Entry is packed MSB..LSB as {opcode, a, b, shamt, tag}.
   function automatic int cmd_entry_bits(input int width);
      return OPC_W + 2 * width + SHAMT_W + TAG_W;
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO for pending ALU commands; pointers carry one extra wrap bit
// so full and empty are told apart without a counter.
module alu_cmd_fifo
   import alu_issue_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues buffered, tagged commands to a combinational ALU, holds its inputs for
// SETTLE cycles, then returns the captured result as a tagged response.
module alu_cmd_issuer
   import alu_issue_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 4,
   parameter int SETTLE  = 1,
   parameter int NUM_OPS = NUM_OPS_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_opcode,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [4:0]       cmd_shamt,
   input  logic [3:0]       cmd_tag,
   output logic [3:0]       alu_opcode,
   output logic [WIDTH-1:0] alu_input1,
   output logic [WIDTH-1:0] alu_input2,
   output logic [4:0]       alu_shiftValue,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry,
   output logic [3:0]       rsp_tag,
   output logic             rsp_illegal,
   output logic             busy
);

   localparam int         EW       = cmd_entry_bits(WIDTH);
   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; the sender holds its payload stable until that edge.

   issue_state_t     state, state_n;
   logic [3:0]       cnt;
   logic [EW-1:0]    fifo_din;
   logic [EW-1:0]    head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             do_pop;
   logic             load_alu;
   logic             mark_illegal;
   logic             capture;
   logic             rsp_done;
   logic             head_legal;
   logic [3:0]       h_op;
   logic [WIDTH-1:0] h_a;
   logic [WIDTH-1:0] h_b;
   logic [4:0]       h_shamt;
   logic [3:0]       h_tag;

   assign fifo_din = {cmd_opcode, cmd_a, cmd_b, cmd_shamt, cmd_tag};
   assign {h_op, h_a, h_b, h_shamt, h_tag} = head;
   assign head_legal = (int'(h_op) < NUM_OPS);

   assign cmd_ready = ~fifo_full;
   assign busy      = (state != ST_IDLE) || !fifo_empty;

   alu_cmd_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid),
      .pop   (do_pop),
      .din   (fifo_din),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n      = state;
      do_pop       = 1'b0;
      load_alu     = 1'b0;
      mark_illegal = 1'b0;
      capture      = 1'b0;
      rsp_done     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               do_pop = 1'b1;
               if (head_legal) begin
                  load_alu = 1'b1;
                  state_n  = ST_DRIVE;
               end else begin
                  mark_illegal = 1'b1;
                  state_n      = ST_RESP;
               end
            end
         end
         ST_DRIVE: begin
            if (cnt == 4'd0) begin
               capture = 1'b1;
               state_n = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_valid && rsp_ready) begin
               rsp_done = 1'b1;
               state_n  = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // ALU drive registers keep their last values between commands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_opcode     <= '0;
         alu_input1     <= '0;
         alu_input2     <= '0;
         alu_shiftValue <= '0;
         cnt            <= '0;
      end else if (load_alu) begin
         alu_opcode     <= h_op;
         alu_input1     <= h_a;
         alu_input2     <= h_b;
         alu_shiftValue <= h_shamt;
         cnt            <= CNT_INIT;
      end else if (state == ST_DRIVE && cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid   <= 1'b0;
         rsp_result  <= '0;
         rsp_carry   <= 1'b0;
         rsp_tag     <= '0;
         rsp_illegal <= 1'b0;
      end else begin
         if (do_pop) rsp_tag <= h_tag;
         if (mark_illegal) begin
            rsp_result  <= '0;
            rsp_carry   <= 1'b0;
            rsp_illegal <= 1'b1;
            rsp_valid   <= 1'b1;
         end else if (capture) begin
            rsp_result  <= alu_result;
            rsp_carry   <= alu_carry & (alu_opcode == ADD);
            rsp_illegal <= 1'b0;
            rsp_valid   <= 1'b1;
         end else if (rsp_done) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: one instance with SETTLE=1, one with
// SETTLE=3, each driving its own 8-bit ALU model.
module tb_alu_cmd_issuer;
   import alu_issue_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [3:0] cmd_opcode;
   logic [7:0] cmd_a, cmd_b;
   logic [4:0] cmd_shamt;
   logic [3:0] cmd_tag;
   logic       force_carry;

   logic       cmd_valid_1, cmd_ready_1, rsp_valid_1, rsp_ready_1, rsp_carry_1, rsp_illegal_1, busy_1, alu_carry_1;
   logic [3:0] alu_opcode_1, rsp_tag_1;
   logic [7:0] alu_input1_1, alu_input2_1, alu_result_1, rsp_result_1;
   logic [4:0] alu_shift_1;

   logic       cmd_valid_3, cmd_ready_3, rsp_valid_3, rsp_ready_3, rsp_carry_3, rsp_illegal_3, busy_3, alu_carry_3;
   logic [3:0] alu_opcode_3, rsp_tag_3;
   logic [7:0] alu_input1_3, alu_input2_3, alu_result_3, rsp_result_3;
   logic [4:0] alu_shift_3;

   int total;
   int bad;

   logic [12:0] exp_q[$];

   function automatic logic [8:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                            input logic fc);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
      case (op)
         SEQ:     return {fc, 7'd0, a == b};
         XNOR:    return {fc, ~(a ^ b)};
         NAND:    return {fc, ~(a & b)};
         AND:     return {fc, a & b};
         SLT:     return {fc, 7'd0, $signed(a) < $signed(b)};
         PASSB:   return {fc, b};
         ADD:     return s;
         MUL:     return {fc, 8'(a * b)};
         SLTU:    return {fc, 7'd0, a < b};
         default: return {fc, 8'h00};
      endcase
   endfunction

   assign {alu_carry_1, alu_result_1} = alu_model(alu_opcode_1, alu_input1_1, alu_input2_1, force_carry);
   assign {alu_carry_3, alu_result_3} = alu_model(alu_opcode_3, alu_input1_3, alu_input2_3, force_carry);

   alu_cmd_issuer #(.WIDTH(8), .DEPTH(4), .SETTLE(1), .NUM_OPS(9)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_1), .cmd_ready(cmd_ready_1),
      .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt), .cmd_tag(cmd_tag),
      .alu_opcode(alu_opcode_1), .alu_input1(alu_input1_1), .alu_input2(alu_input2_1),
      .alu_shiftValue(alu_shift_1), .alu_result(alu_result_1), .alu_carry(alu_carry_1),
      .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1), .rsp_result(rsp_result_1),
      .rsp_carry(rsp_carry_1), .rsp_tag(rsp_tag_1), .rsp_illegal(rsp_illegal_1), .busy(busy_1)
   );

   alu_cmd_issuer #(.WIDTH(8), .DEPTH(4), .SETTLE(3), .NUM_OPS(9)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready_3),
      .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt), .cmd_tag(cmd_tag),
      .alu_opcode(alu_opcode_3), .alu_input1(alu_input1_3), .alu_input2(alu_input2_3),
      .alu_shiftValue(alu_shift_3), .alu_result(alu_result_3), .alu_carry(alu_carry_3),
      .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_result(rsp_result_3),
      .rsp_carry(rsp_carry_3), .rsp_tag(rsp_tag_3), .rsp_illegal(rsp_illegal_3), .busy(busy_3)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Driver: returns 1 ns after the edge on which the command was accepted.
   task automatic push(input bit s3, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] tag);
      int n;
      n = 0;
      cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_shamt = 5'd0; cmd_tag = tag;
      if (s3) cmd_valid_3 = 1'b1;
      else    cmd_valid_1 = 1'b1;
      while (!(s3 ? cmd_ready_3 : cmd_ready_1) && n < 50) begin
         tick();
         n++;
      end
      total++;
      if (n >= 50) begin bad++; $display("FAIL push_timeout: got cmd_ready=0 for %0d cycles, want 1", n); end
      tick();
      cmd_valid_1 = 1'b0;
      cmd_valid_3 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cmd_valid_1 = 0; cmd_valid_3 = 0; rsp_ready_1 = 0; rsp_ready_3 = 0; force_carry = 0;
      cmd_opcode = 0; cmd_a = 0; cmd_b = 0; cmd_shamt = 0; cmd_tag = 0;
      tick(); tick();
      total++; if (cmd_ready_1 !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready_1); end
      total++; if (rsp_valid_1 !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_1); end
      total++; if (busy_1 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_1); end
      total++; if (alu_opcode_1 !== 4'd0) begin bad++; $display("FAIL reset_alu_opcode: got %h want 0", alu_opcode_1); end
      total++; if ({rsp_result_1, rsp_tag_1, rsp_carry_1, rsp_illegal_1} !== 14'd0) begin
         bad++; $display("FAIL reset_rsp_fields: got %h/%h/%b/%b want 0", rsp_result_1, rsp_tag_1, rsp_carry_1, rsp_illegal_1);
      end
      total++; if (cmd_ready_3 !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready3: got %b want 1", cmd_ready_3); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_add();
      rsp_ready_1 = 1'b1;
      push(0, ADD, 8'hF0, 8'h20, 4'd3);
      total++; if (rsp_valid_1 !== 1'b0 || busy_1 !== 1'b1) begin
         bad++; $display("FAIL add_edge_k: got valid=%b busy=%b want 0/1", rsp_valid_1, busy_1);
      end
      tick();
      total++; if (rsp_valid_1 !== 1'b0) begin bad++; $display("FAIL add_edge_k1_valid: got %b want 0", rsp_valid_1); end
      total++; if (alu_opcode_1 !== ADD) begin bad++; $display("FAIL add_alu_opcode: got %h want 6", alu_opcode_1); end
      tick();
      total++; if (rsp_valid_1 !== 1'b1) begin bad++; $display("FAIL add_edge_k2_valid: got %b want 1", rsp_valid_1); end
      total++; if (rsp_result_1 !== 8'h10) begin bad++; $display("FAIL add_result: got %h want 10", rsp_result_1); end
      total++; if (rsp_carry_1 !== 1'b1) begin bad++; $display("FAIL add_carry: got %b want 1", rsp_carry_1); end
      total++; if (rsp_tag_1 !== 4'd3 || rsp_illegal_1 !== 1'b0) begin
         bad++; $display("FAIL add_tag_illegal: got %h/%b want 3/0", rsp_tag_1, rsp_illegal_1);
      end
      tick();
      total++; if (rsp_valid_1 !== 1'b0) begin bad++; $display("FAIL add_handshake: got valid=%b want 0", rsp_valid_1); end
      tick();
      total++; if (busy_1 !== 1'b0) begin bad++; $display("FAIL add_idle_busy: got %b want 0", busy_1); end
   endtask

   task automatic test_and_carry_mask();
      force_carry = 1'b1;
      push(0, AND, 8'hCC, 8'hAA, 4'd5);
      tick(); tick();
      total++; if (rsp_valid_1 !== 1'b1) begin bad++; $display("FAIL and_valid: got %b want 1", rsp_valid_1); end
      total++; if (rsp_result_1 !== 8'h88) begin bad++; $display("FAIL and_result: got %h want 88", rsp_result_1); end
      total++; if (rsp_carry_1 !== 1'b0) begin bad++; $display("FAIL and_carry_mask: got %b want 0", rsp_carry_1); end
      total++; if (rsp_tag_1 !== 4'd5) begin bad++; $display("FAIL and_tag: got %h want 5", rsp_tag_1); end
      tick(); tick();
      force_carry = 1'b0;
   endtask

   task automatic test_illegal();
      rsp_ready_1 = 1'b0;
      push(0, 4'd12, 8'h33, 8'h44, 4'd9);
      total++; if (rsp_valid_1 !== 1'b0) begin bad++; $display("FAIL ill_edge_k_valid: got %b want 0", rsp_valid_1); end
      tick();
      total++; if (rsp_valid_1 !== 1'b1) begin bad++; $display("FAIL ill_edge_k1_valid: got %b want 1", rsp_valid_1); end
      total++; if (rsp_illegal_1 !== 1'b1) begin bad++; $display("FAIL ill_flag: got %b want 1", rsp_illegal_1); end
      total++; if (rsp_result_1 !== 8'h00 || rsp_carry_1 !== 1'b0) begin
         bad++; $display("FAIL ill_result: got %h/%b want 00/0", rsp_result_1, rsp_carry_1);
      end
      total++; if (rsp_tag_1 !== 4'd9) begin bad++; $display("FAIL ill_tag: got %h want 9", rsp_tag_1); end
      total++; if (alu_opcode_1 !== AND || alu_input1_1 !== 8'hCC) begin
         bad++; $display("FAIL ill_alu_hold: got %h/%h want 3/cc", alu_opcode_1, alu_input1_1);
      end
      rsp_ready_1 = 1'b1;
      tick();
      total++; if (rsp_valid_1 !== 1'b0) begin bad++; $display("FAIL ill_handshake: got %b want 0", rsp_valid_1); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [3:0]  ops  [5] = '{ADD, XNOR, MUL, SLT, ADD};
      logic [7:0]  as   [5] = '{8'h01, 8'h0F, 8'h05, 8'h80, 8'hC8};
      logic [7:0]  bs   [5] = '{8'h02, 8'hA5, 8'h07, 8'h01, 8'h64};
      logic [12:0] exps [5] = '{{8'h03, 1'b0, 4'd1}, {8'h55, 1'b0, 4'd2}, {8'h23, 1'b0, 4'd3},
                                {8'h01, 1'b0, 4'd4}, {8'h2C, 1'b1, 4'd5}};
      logic [12:0] e;
      int got;
      rsp_ready_1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push(0, ops[i], as[i], bs[i], 4'(i + 1));
         exp_q.push_back(exps[i]);
      end
      cmd_opcode = SEQ; cmd_a = 8'h77; cmd_b = 8'h77; cmd_tag = 4'd6;
      cmd_valid_1 = 1'b1;
      total++; if (cmd_ready_1 !== 1'b0) begin bad++; $display("FAIL b2b_full: got cmd_ready=%b want 0", cmd_ready_1); end
      total++; if (rsp_valid_1 !== 1'b1 || rsp_tag_1 !== 4'd1) begin
         bad++; $display("FAIL b2b_first_popped: got valid=%b tag=%h want 1/1", rsp_valid_1, rsp_tag_1);
      end
      tick();
      cmd_valid_1 = 1'b0;
      rsp_ready_1 = 1'b1;
      got = 0;
      for (int c = 0; c < 100 && got < 5; c++) begin
         if (rsp_valid_1) begin
            e = exp_q.pop_front();
            total++;
            if ({rsp_result_1, rsp_carry_1, rsp_tag_1} !== e) begin
               bad++; $display("FAIL b2b_rsp%0d: got %h/%b/%h want %h/%b/%h", got, rsp_result_1, rsp_carry_1,
                               rsp_tag_1, e[12:5], e[4], e[3:0]);
            end
            got++;
         end
         tick();
      end
      total++; if (got != 5) begin bad++; $display("FAIL b2b_count: got %0d responses want 5", got); end
      tick(); tick();
      total++; if (busy_1 !== 1'b0 || rsp_valid_1 !== 1'b0) begin
         bad++; $display("FAIL b2b_drained: got busy=%b valid=%b want 0/0 (sixth must not be queued)", busy_1, rsp_valid_1);
      end
   endtask

   task automatic test_hold_settle3();
      int unstable;
      rsp_ready_3 = 1'b0;
      push(1, PASSB, 8'h11, 8'h5A, 4'd7);
      tick(); tick(); tick();
      total++; if (rsp_valid_3 !== 1'b0) begin bad++; $display("FAIL s3_edge_k3_valid: got %b want 0", rsp_valid_3); end
      total++; if (alu_input2_3 !== 8'h5A || alu_opcode_3 !== PASSB) begin
         bad++; $display("FAIL s3_alu_drive: got %h/%h want 5/5a", alu_opcode_3, alu_input2_3);
      end
      tick();
      total++; if (rsp_valid_3 !== 1'b1) begin bad++; $display("FAIL s3_edge_k4_valid: got %b want 1", rsp_valid_3); end
      unstable = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if ({rsp_valid_3, rsp_result_3, rsp_carry_3, rsp_tag_3, rsp_illegal_3, busy_3} !==
             {1'b1, 8'h5A, 1'b0, 4'd7, 1'b0, 1'b1}) unstable++;
      end
      total++; if (unstable != 0) begin bad++; $display("FAIL s3_hold: got %0d unstable cycles want 0", unstable); end
      rsp_ready_3 = 1'b1;
      tick();
      total++; if (rsp_valid_3 !== 1'b0 || busy_3 !== 1'b0) begin
         bad++; $display("FAIL s3_release: got valid=%b busy=%b want 0/0", rsp_valid_3, busy_3);
      end
   endtask

   task automatic test_reset_mid_drive();
      int seen;
      rsp_ready_1 = 1'b1;
      push(0, ADD, 8'h7F, 8'h01, 4'd6);
      tick();
      total++; if (busy_1 !== 1'b1 || alu_opcode_1 !== ADD) begin
         bad++; $display("FAIL rst_pre_drive: got busy=%b op=%h want 1/6", busy_1, alu_opcode_1);
      end
      rst_n = 1'b0;
      #1;
      total++; if (rsp_valid_1 !== 1'b0 || cmd_ready_1 !== 1'b1 || busy_1 !== 1'b0) begin
         bad++; $display("FAIL rst_async: got valid=%b ready=%b busy=%b want 0/1/0", rsp_valid_1, cmd_ready_1, busy_1);
      end
      total++; if (alu_opcode_1 !== 4'd0) begin bad++; $display("FAIL rst_alu_opcode: got %h want 0", alu_opcode_1); end
      tick(); tick();
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (rsp_valid_1 !== 1'b0) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL rst_no_rsp: got valid high %0d cycles want 0", seen); end
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_add();
      test_and_carry_mask();
      test_illegal();
      test_back_to_back();
      test_hold_settle3();
      test_reset_mid_drive();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
